// File: rtl/sign_extend_pkg.sv
// Shared opcode encodings and width constants for the immediate extension unit.
package sign_extend_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_op_e;

endpackage

// File: rtl/sign_extend_core.sv
// Purely combinational immediate extension: sign, zero, upper-load and branch offset.
module sign_extend_core #(
    parameter int IN_W  = sign_extend_pkg::IN_W,
    parameter int OUT_W = sign_extend_pkg::OUT_W
) (
    input  logic [1:0]       opcode,
    input  logic [IN_W-1:0]  extend,
    output logic [OUT_W-1:0] result
);
    import sign_extend_pkg::*;

    logic [OUT_W-1:0] sext;

    // extend's MSB is the only sign source; the branch form reuses the sign-extended value.
    assign sext = {{(OUT_W-IN_W){extend[IN_W-1]}}, extend};

    always_comb begin
        result = '0;
        case (ext_op_e'(opcode))
            EXT_SIGN:   result = sext;
            EXT_ZERO:   result = {{(OUT_W-IN_W){1'b0}}, extend};
            EXT_UPPER:  result = {extend, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: result = sext << 2;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/sign_extend.sv
// Registered immediate extension unit: one-cycle latency, valid-qualified capture.
module sign_extend #(
    parameter int IN_W  = sign_extend_pkg::IN_W,
    parameter int OUT_W = sign_extend_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       opcode,
    input  logic [IN_W-1:0]  extend,
    output logic [OUT_W-1:0] extended,
    output logic             out_valid
);
    // Handshake: valid-only, no backpressure. A cycle with in_valid high is captured on
    // the next rising clk; out_valid pulses for exactly that following cycle. extended
    // holds its last captured value otherwise.

    logic [OUT_W-1:0] core_result;

    sign_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .opcode (opcode),
        .extend (extend),
        .result (core_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            extended  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                extended <= core_result;
            end
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Directed and random checks of sign_extend against a scoreboard of expected results.
module tb_sign_extend;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  opcode;
    logic [15:0] extend;
    logic [31:0] extended;
    logic        out_valid;

    logic [31:0] exp_q[$];
    logic [31:0] last_ext;
    int          n_assert;
    int          n_fail;

    sign_extend dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .extend    (extend),
        .extended  (extended),
        .out_valid (out_valid)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [15:0] ext);
        logic signed [31:0] s;
        logic [31:0]        r;
        s = $signed(ext);
        case (op)
            2'd0:    r = s;
            2'd1:    r = 32'(ext);
            2'd2:    r = 32'(ext) * 32'h0001_0000;
            default: r = s * 4;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: present one input cycle, then check what the DUT produced for it
    task automatic step(input string tag, input logic v, input logic [1:0] op,
                        input logic [15:0] ext, input logic [31:0] exp_val);
        logic [31:0] e;
        in_valid = v;
        opcode   = op;
        extend   = ext;
        if (v) exp_q.push_back(exp_val);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_underflow"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check(tag, extended, e);
                last_ext = e;
            end
        end else begin
            check({tag, "_hold"}, extended, last_ext);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        last_ext = 32'h0;
        reset    = 1'b1;
        in_valid = 1'b0;
        opcode   = 2'b00;
        extend   = 16'h0000;

        // reset state, and in_valid ignored while reset is high
        @(negedge clk);
        @(negedge clk);
        check("rst_ext", extended, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b1;
        extend   = 16'hFFFF;
        @(negedge clk);
        check("rst_ign_ext", extended, 32'h0);
        check("rst_ign_valid", 32'(out_valid), 32'h0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'h0);

        // directed single vectors
        step("sign_f00f",  1'b1, 2'b00, 16'hF00F, 32'hFFFFF00F);
        step("idle_0",     1'b0, 2'b11, 16'h1234, 32'h0);
        step("sign_0ff0",  1'b1, 2'b00, 16'h0FF0, 32'h00000FF0);
        step("zero_f00f",  1'b1, 2'b01, 16'hF00F, 32'h0000F00F);
        step("upper_f00f", 1'b1, 2'b10, 16'hF00F, 32'hF00F0000);
        step("br_f00f",    1'b1, 2'b11, 16'hF00F, 32'hFFFFC03C);
        step("sign_8000",  1'b1, 2'b00, 16'h8000, 32'hFFFF8000);
        step("sign_7fff",  1'b1, 2'b00, 16'h7FFF, 32'h00007FFF);
        step("br_7fff",    1'b1, 2'b11, 16'h7FFF, 32'h0001FFFC);
        step("idle_1",     1'b0, 2'b00, 16'h0000, 32'h0);

        // back-to-back burst, then inputs toggling with in_valid low
        step("b2b_0", 1'b1, 2'b00, 16'hF00F, 32'hFFFFF00F);
        step("b2b_1", 1'b1, 2'b01, 16'hF00F, 32'h0000F00F);
        step("b2b_2", 1'b1, 2'b10, 16'hF00F, 32'hF00F0000);
        step("b2b_3", 1'b1, 2'b11, 16'hF00F, 32'hFFFFC03C);
        for (int i = 0; i < 4; i++) begin
            step("toggle", 1'b0, 2'(i), 16'(16'hA5A5 ^ (i * 16'h1111)), 32'h0);
        end

        // reset asserted between edges with a capture pending
        step("pre_rst", 1'b1, 2'b00, 16'hF00F, 32'hFFFFF00F);
        in_valid = 1'b1;
        opcode   = 2'b01;
        extend   = 16'h1357;
        #2 reset = 1'b1;
        #1;
        check("async_rst_ext", extended, 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        exp_q.delete();
        last_ext = 32'h0;
        @(negedge clk);
        check("rst_hold_ext", extended, 32'h0);
        check("rst_hold_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("post_rst_idle", 1'b0, 2'b10, 16'hFFFF, 32'h0);
        end

        // random traffic
        for (int i = 0; i < 40; i++) begin
            logic        v;
            logic [1:0]  op;
            logic [15:0] ext;
            v   = 1'($urandom_range(0, 3) != 0);
            op  = 2'($urandom_range(0, 3));
            ext = 16'($urandom_range(0, 16'hFFFF));
            step("rand", v, op, ext, model(op, ext));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("final_valid", 32'(out_valid), 32'h0);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_extend.md
SIGN_EXTEND -- requirements
Module: sign_extend

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; only 16 is required to be supported.
REQ-002 Parameter OUT_W, default 32, extended output width; only 32 is required to be supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset; asynchronous and active-high.
REQ-005 in_valid  input  1  qualifies opcode/extend for capture this cycle.
REQ-006 opcode  input  2  extension mode select.
REQ-007 extend  input  16  immediate field to extend.
REQ-008 extended  output  32  registered extension result.
REQ-009 out_valid  output  1  high for one cycle when extended carries a new result.

Function
REQ-010 Mode 00 SHALL sign-extend: extended = {16{extend[15]}, extend}.
REQ-011 Mode 01 SHALL zero-extend: extended = {16'h0000, extend}.
REQ-012 Mode 10 SHALL upper-load: extended = {extend, 16'h0000}.
REQ-013 Mode 11 SHALL produce a branch offset: sign-extend as mode 00, then shift left by 2; the top two bits are discarded and the two LSBs are zero.
REQ-014 The result SHALL be computed combinationally from opcode/extend and registered; latency is exactly 1 clock from an in_valid cycle to out_valid/extended.
REQ-015 out_valid SHALL equal in_valid delayed by one cycle; back-to-back in_valid SHALL give back-to-back results, one per cycle, with no bubbles.
REQ-016 When in_valid is low, extended SHALL hold its last value and out_valid SHALL be 0 on the next cycle.
REQ-017 extend[15] SHALL be the only sign source; 0x8000 in mode 00 gives 0xFFFF8000, and 0x7FFF gives 0x00007FFF.
REQ-018 Opcode and extend changes during a cycle without in_valid SHALL have no effect on the outputs.
REQ-019 There SHALL be no X propagation from a known input; every opcode value is defined, with no illegal encodings.

Reset
REQ-020 Asserting reset SHALL immediately, without waiting for clk, force extended = 0x00000000 and out_valid = 0.
REQ-021 While reset is high, in_valid SHALL be ignored.
REQ-022 The first capture SHALL occur on the first rising clk edge after reset deasserts on which in_valid is high.
REQ-023 Reset asserted mid-stream SHALL discard any pending result; no out_valid pulse follows reset deassertion unless in_valid is newly applied.

Structure
REQ-024 A shared package SHALL hold the opcode encodings: EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11.
REQ-025 The same package SHALL hold the width constants IN_W=16 and OUT_W=32.
REQ-026 One combinational sub-module, sign_extend_core, SHALL compute the 32-bit result from opcode and extend.
REQ-027 The top level SHALL contain only the output register stage and the valid pipeline.

Verification
REQ-028 op=00, extend=0xF00F, in_valid=1 -> next cycle extended=0xFFFFF00F, out_valid=1.
REQ-029 op=00, extend=0x0FF0 -> extended=0x00000FF0; op=01, extend=0xF00F -> extended=0x0000F00F.
REQ-030 op=10, extend=0xF00F -> extended=0xF00F0000; op=11, extend=0xF00F -> extended=0xFFFFC03C.
REQ-031 Four back-to-back inputs (ops 00,01,10,11, extend=0xF00F) -> four consecutive out_valid cycles with the results above, in order.
REQ-032 Assert reset between clk edges while extended=0xFFFFF00F -> extended=0 and out_valid=0 immediately; hold in_valid=0 after release -> outputs stay 0.
REQ-033 in_valid=0 while opcode/extend toggle -> extended unchanged and out_valid=0.
